// File: rtl/hazard_lock_unit.sv
// hazard_lock_unit: load-use / memBusy stall control for the DEC->ALU pipeline register
module hazard_lock_unit #(
    parameter int           LOAD_STALL_CYCLES = 1,
    parameter logic [6:0]   OPCODE_LOAD       = 7'b0000011,
    parameter int           CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opCodeToHazard,
    input  logic [4:0]       exWriteBackAddr,
    input  logic             exWriteEnable,
    input  logic             flag,
    input  logic [4:0]       decRs1Addr,
    input  logic [4:0]       decRs2Addr,
    input  logic             decUseRs1,
    input  logic             decUseRs2,
    input  logic             memBusy,
    output logic             locker,
    output logic             CSLToALUMEM,
    output logic             pcHold,
    output logic             ifidHold,
    output logic             lockError,
    output logic [CNT_W-1:0] stallCount
);
    typedef enum logic {RUN, LOADUSE} state_t;
    localparam logic       MULTI   = LOAD_STALL_CYCLES > 1;
    localparam logic [2:0] LU_INIT = 3'(LOAD_STALL_CYCLES - 1);
    state_t     state, state_nx;
    logic [2:0] cnt, cnt_nx;
    logic       lu_haz, stall, prev_locker;
    assign lu_haz = (opCodeToHazard == OPCODE_LOAD) && exWriteEnable && (exWriteBackAddr != 5'd0)
                  && ((decUseRs1 && decRs1Addr == exWriteBackAddr) || (decUseRs2 && decRs2Addr == exWriteBackAddr));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
            cnt   <= 3'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end
    // memBusy freezes the bubble sequence so the remaining count resumes afterwards
    always_comb begin
        state_nx = memBusy ? state : state == RUN ? ((lu_haz && MULTI) ? LOADUSE : RUN) : (cnt == 3'd1 ? RUN : LOADUSE);
        cnt_nx   = memBusy ? cnt : state == RUN ? ((lu_haz && MULTI) ? LU_INIT : 3'd0) : cnt - 3'd1;
    end
    always_comb begin
        stall       = state == LOADUSE || lu_haz;
        locker      = reset || !memBusy;
        CSLToALUMEM = !reset && (memBusy || !stall);
        pcHold      = !reset && (memBusy || stall);
        ifidHold    = pcHold;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_locker <= 1'b1;
            lockError   <= 1'b0;
            stallCount  <= '0;
        end else begin
            prev_locker <= locker;
            if (flag != prev_locker) lockError <= 1'b1;
            if (pcHold && !(&stallCount)) stallCount <= stallCount + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_lock_unit.sv
// tb_hazard_lock_unit: table-driven scoreboard bench for two parameterisations of hazard_lock_unit
module tb_hazard_lock_unit;
    typedef struct {
        bit         sel;
        logic       rst, mb;
        logic [6:0] op;
        logic [4:0] rd;
        logic       we;
        logic [4:0] rs1, rs2;
        logic       u1, u2, lk, csl, pch, lerr;
    } vec_t;
    typedef struct {
        int          id;
        bit          sel;
        logic [4:0]  o;
        logic [31:0] scnt;
    } exp_t;
    localparam logic [6:0] LD = 7'b0000011;
    localparam logic [6:0] AL = 7'b0110011;
    logic clk, reset, we, flag, u1, u2, mb;
    logic [6:0] op;
    logic [4:0] rd, rs1, rs2;
    logic lk_a, csl_a, pch_a, ifh_a, le_a;
    logic lk_b, csl_b, pch_b, ifh_b, le_b;
    logic [2:0]  sc_a;
    logic [31:0] sc_b;
    exp_t sb[$];
    vec_t tbl[$];
    int n_cmp = 0, n_bad = 0;
    logic last_lk;
    logic [31:0] mc;

    hazard_lock_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(3)) u_a (
        .clk(clk), .reset(reset), .opCodeToHazard(op), .exWriteBackAddr(rd), .exWriteEnable(we),
        .flag(flag), .decRs1Addr(rs1), .decRs2Addr(rs2), .decUseRs1(u1), .decUseRs2(u2), .memBusy(mb),
        .locker(lk_a), .CSLToALUMEM(csl_a), .pcHold(pch_a), .ifidHold(ifh_a), .lockError(le_a), .stallCount(sc_a));
    hazard_lock_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) u_b (
        .clk(clk), .reset(reset), .opCodeToHazard(op), .exWriteBackAddr(rd), .exWriteEnable(we),
        .flag(flag), .decRs1Addr(rs1), .decRs2Addr(rs2), .decUseRs1(u1), .decUseRs2(u2), .memBusy(mb),
        .locker(lk_b), .CSLToALUMEM(csl_b), .pcHold(pch_b), .ifidHold(ifh_b), .lockError(le_b), .stallCount(sc_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input bit sel, input logic rst, mb, input logic [6:0] o, input logic [4:0] d,
                               input logic w, input logic [4:0] s1, s2, input logic a1, a2, elk, ecsl, epch, eerr);
        vec_t x;
        x.sel = sel; x.rst = rst; x.mb = mb; x.op = o; x.rd = d; x.we = w; x.rs1 = s1; x.rs2 = s2;
        x.u1 = a1; x.u2 = a2; x.lk = elk; x.csl = ecsl; x.pch = epch; x.lerr = eerr;
        return x;
    endfunction

    task automatic apply(input vec_t x, input int id, input bit fo);
        exp_t e;
        @(posedge clk);
        #1;
        reset = x.rst; mb = x.mb; op = x.op; rd = x.rd; we = x.we;
        rs1 = x.rs1; rs2 = x.rs2; u1 = x.u1; u2 = x.u2;
        flag = fo ? 1'b0 : last_lk;
        last_lk = x.rst | ~x.mb;
        e.id = id; e.sel = x.sel; e.o = {x.lk, x.csl, x.pch, x.pch, x.lerr}; e.scnt = mc;
        mc = x.rst ? 32'd0 : (x.pch && mc != (x.sel ? 32'hFFFF_FFFF : 32'd7)) ? mc + 32'd1 : mc;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [4:0] a;
            logic [31:0] s;
            e = sb.pop_front();
            a = e.sel ? {lk_b, csl_b, pch_b, ifh_b, le_b} : {lk_a, csl_a, pch_a, ifh_a, le_a};
            s = e.sel ? sc_b : {29'd0, sc_a};
            n_cmp++;
            if (a !== e.o) begin
                n_bad++;
                $display("FAIL v%0d outs{locker,csl,pcHold,ifidHold,lockError} got %b want %b", e.id, a, e.o);
            end
            n_cmp++;
            if (s !== e.scnt) begin
                n_bad++;
                $display("FAIL v%0d stallCount got %0d want %0d", e.id, s, e.scnt);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mb = 1'b0; op = '0; rd = '0; we = 1'b0; rs1 = '0; rs2 = '0;
        u1 = 1'b0; u2 = 1'b0; flag = 1'b1; last_lk = 1'b1; mc = 32'd0;
        repeat (2) @(posedge clk);
        repeat (3) tbl.push_back(v(0, 1, 0, AL, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, AL, 5, 1, 5, 1, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LD, 5, 1, 5, 1, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LD, 7, 1, 1, 7, 1, 1, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, LD, 7, 0, 1, 7, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LD, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LD, 5, 1, 1, 5, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 1, LD, 5, 1, 5, 1, 1, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        repeat (6) tbl.push_back(v(0, 0, 1, AL, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(0, 0, 0, AL, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 0, 0, LD, 5, 1, 5, 1, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(0, 0, 0, AL, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, AL, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(v(1, 0, 0, LD, 5, 1, 5, 1, 1, 0, 1, 0, 1, 0));
        repeat (2) tbl.push_back(v(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 5, 1, 1, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 0, 0, LD, 5, 1, 5, 1, 1, 0, 1, 0, 1, 0));
        repeat (4) tbl.push_back(v(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        repeat (2) tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i, 1'b0);
        apply(v(1, 0, 0, LD, 5, 1, 5, 1, 1, 0, 1, 0, 1, 0), 50, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 51, 1'b0);
        apply(v(1, 0, 0, LD, 6, 1, 6, 1, 1, 0, 1, 0, 1, 0), 52, 1'b0);
        apply(v(1, 0, 0, LD, 6, 1, 6, 1, 1, 0, 1, 0, 1, 0), 53, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0), 54, 1'b0);
        apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 55, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 56, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 100, 1'b1);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 101, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1), 102, 1'b0);
        apply(v(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1), 103, 1'b0);
        apply(v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 104, 1'b0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
